// File: rtl/wb_burst_master_if.sv
// Wishbone B4 bus bundle between the burst master and its slave.
// Signal names keep the master-side _o/_i suffixes so waveforms match the core.
interface wb_burst_master_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int SW = DW / 8;

   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [SW-1:0] wb_sel_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_we_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic          wb_rty_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
             wb_cyc_o, wb_stb_o, wb_we_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
             wb_cyc_o, wb_stb_o, wb_we_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing/wrapping burst master driven by a single command.
// Optional wrap bursts are enabled by defining OPTIMSOC_WB_BURST_WRAP_EN.
module wb_burst_master #(
   parameter int AW = 32,
   parameter int DW = 32,
   localparam int SW = DW / 8
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready. rdata has no ready (no backpressure).
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic          cmd_we,
   input  logic [3:0]    cmd_len,
   input  logic [SW-1:0] cmd_sel,
   input  logic          cmd_wrap,

   input  logic          wdata_valid,
   output logic          wdata_ready,
   input  logic [DW-1:0] wdata,

   output logic          rdata_valid,
   output logic [DW-1:0] rdata,
   output logic          rdata_last,

   output logic          done,
   output logic          done_err,

   output logic [1:0]    dbg_state,

   wb_burst_master_if.master wb
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [AW-1:0] adr_q;
   logic [AW-1:0] adr_next;
   logic          we_q;
   logic [SW-1:0] sel_q;
   logic [3:0]    len_q;
   logic [3:0]    cnt_q;
   logic          err_q;
   logic [4:0]    drain_q;
   logic [1:0]    bte_cur;

   logic          cmd_fire;
   logic          stb;
   logic          bus_err;
   logic          beat_ok;
   logic          last_beat;

   assign cmd_fire  = cmd_valid & (state_q == IDLE);
   assign last_beat = (cnt_q == len_q);
   // Writes only strobe when a data word is on offer, so address and count stall with it.
   assign stb       = (state_q == BURST) & (~we_q | wdata_valid);
   assign bus_err   = stb & (wb.wb_err_i | wb.wb_rty_i);
   assign beat_ok   = stb & wb.wb_ack_i & ~(wb.wb_err_i | wb.wb_rty_i);

`ifdef OPTIMSOC_WB_BURST_WRAP_EN
   logic [AW-1:0] wrap_mask_q;
   logic [1:0]    bte_q;
   logic          wrap_ok;

   assign wrap_ok = cmd_wrap &
                    ((cmd_len == 4'd3) | (cmd_len == 4'd7) | (cmd_len == 4'd15));

   // Bits under the mask step within the aligned wrap block; bits above stay fixed.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wrap_mask_q <= '1;
         bte_q       <= 2'b00;
      end else if (cmd_fire) begin
         if (wrap_ok) begin
            wrap_mask_q <= AW'((32'(cmd_len) + 32'd1) * SW - 1);
            case (cmd_len)
               4'd3:    bte_q <= 2'b01;
               4'd7:    bte_q <= 2'b10;
               default: bte_q <= 2'b11;
            endcase
         end else begin
            wrap_mask_q <= '1;
            bte_q       <= 2'b00;
         end
      end
   end

   assign adr_next = (adr_q & ~wrap_mask_q) | ((adr_q + AW'(SW)) & wrap_mask_q);
   assign bte_cur  = bte_q;
`else
   logic unused_cmd_wrap;

   assign unused_cmd_wrap = cmd_wrap;
   assign adr_next        = adr_q + AW'(SW);
   assign bte_cur         = 2'b00;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) state_d = BURST;
         end
         BURST: begin
            // An error on the final beat leaves no words to drain.
            if (bus_err) begin
               state_d = (we_q && !last_beat) ? DRAIN : DONE;
            end else if (beat_ok && last_beat) begin
               state_d = DONE;
            end
         end
         DRAIN: begin
            if (wdata_valid && (drain_q == 5'd1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
      done        = 1'b0;
      done_err    = 1'b0;
      wb.wb_cyc_o = 1'b0;
      wb.wb_stb_o = 1'b0;
      wb.wb_cti_o = 3'b000;
      wb.wb_bte_o = 2'b00;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
         end
         BURST: begin
            wb.wb_cyc_o = 1'b1;
            wb.wb_stb_o = stb;
            wb.wb_cti_o = (len_q == 4'd0) ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
            wb.wb_bte_o = bte_cur;
            wdata_ready = we_q & beat_ok;
            rdata_valid = ~we_q & beat_ok;
            rdata_last  = ~we_q & beat_ok & last_beat;
         end
         DRAIN: begin
            wdata_ready = 1'b1;
         end
         DONE: begin
            done     = 1'b1;
            done_err = err_q;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         len_q   <= 4'd0;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         drain_q <= 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_fire) begin
                  adr_q <= cmd_addr;
                  we_q  <= cmd_we;
                  sel_q <= cmd_sel;
                  len_q <= cmd_len;
                  cnt_q <= 4'd0;
                  err_q <= 1'b0;
               end
            end
            BURST: begin
               // The errored word was not taken, so it is part of what must be drained.
               if (bus_err) begin
                  err_q   <= 1'b1;
                  drain_q <= 5'(len_q) + 5'd1 - 5'(cnt_q);
               end else if (beat_ok) begin
                  cnt_q <= cnt_q + 4'd1;
                  adr_q <= adr_next;
               end
            end
            DRAIN: begin
               if (wdata_valid) drain_q <= drain_q - 5'd1;
            end
            default: begin
               drain_q <= drain_q;
            end
         endcase
      end
   end

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_dat_o = wdata;
   assign rdata       = wb.wb_dat_i;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomised scoreboard bench for wb_burst_master with a responding Wishbone slave.
`timescale 1ns/1ps
module tb_wb_burst_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic          cmd_we = 1'b0;
   logic [3:0]    cmd_len = 4'd0;
   logic [SW-1:0] cmd_sel = '0;
   logic          cmd_wrap = 1'b0;
   logic          wdata_valid = 1'b0;
   logic          wdata_ready;
   logic [DW-1:0] wdata = '0;
   logic          rdata_valid;
   logic [DW-1:0] rdata;
   logic          rdata_last;
   logic          done;
   logic          done_err;
   logic [1:0]    dbg_state;

   wb_burst_master_if #(.AW(AW), .DW(DW)) wb_bus ();

   wb_burst_master #(.AW(AW), .DW(DW)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_we      (cmd_we),
      .cmd_len     (cmd_len),
      .cmd_sel     (cmd_sel),
      .cmd_wrap    (cmd_wrap),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .rdata_last  (rdata_last),
      .done        (done),
      .done_err    (done_err),
      .dbg_state   (dbg_state),
      .wb          (wb_bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] adr;
      logic [2:0]    cti;
      logic [1:0]    bte;
      logic          we;
      logic [SW-1:0] sel;
      logic [DW-1:0] dat;
   } beat_t;

   beat_t         exp_beat_q[$];
   logic [DW:0]   exp_q[$];
   logic          exp_done_q[$];

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc_cnt = 0;
   int            last_resp_cyc = 0;
   int            stall_pct = 0;
   int            gap_pct = 0;
   int            err_beat = -1;
   int            slv_beat = 0;
   logic          mon_en = 1'b0;
   logic [DW-1:0] salt = '0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[15:0] ^ salt[15:0], ~a[15:0]};
   endfunction

   // slave: responds to strobes after random stalls, errors on the chosen beat
   initial begin
      wb_bus.wb_ack_i = 1'b0;
      wb_bus.wb_err_i = 1'b0;
      wb_bus.wb_rty_i = 1'b0;
      wb_bus.wb_dat_i = '0;
      forever begin
         @(posedge clk);
         #2;
         wb_bus.wb_ack_i = 1'b0;
         wb_bus.wb_err_i = 1'b0;
         wb_bus.wb_rty_i = 1'b0;
         if (!rst && wb_bus.wb_cyc_o && wb_bus.wb_stb_o &&
             (int'($urandom_range(99)) >= stall_pct)) begin
            wb_bus.wb_dat_i = mem_word(wb_bus.wb_adr_o);
            if (slv_beat == err_beat) begin
               case ($urandom_range(2))
                  0:       wb_bus.wb_err_i = 1'b1;
                  1:       wb_bus.wb_rty_i = 1'b1;
                  default: begin
                     wb_bus.wb_err_i = 1'b1;
                     wb_bus.wb_ack_i = 1'b1;
                  end
               endcase
            end else begin
               wb_bus.wb_ack_i = 1'b1;
            end
            slv_beat++;
         end
      end
   end

   // monitor: pops expectations whenever the DUT presents a beat, read word or done
   beat_t       mon_b;
   logic [DW:0] mon_r;
   logic        mon_d;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && mon_en) begin
            if (wb_bus.wb_cyc_o && wb_bus.wb_stb_o &&
                (wb_bus.wb_ack_i || wb_bus.wb_err_i || wb_bus.wb_rty_i)) begin
               last_resp_cyc = cyc_cnt;
               if (exp_beat_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_beat: adr 0x%0h, expected no beat", wb_bus.wb_adr_o);
               end else begin
                  mon_b = exp_beat_q.pop_front();
                  check("beat_adr", wb_bus.wb_adr_o, mon_b.adr);
                  check("beat_cti", wb_bus.wb_cti_o, mon_b.cti);
                  check("beat_bte", wb_bus.wb_bte_o, mon_b.bte);
                  check("beat_we", wb_bus.wb_we_o, mon_b.we);
                  check("beat_sel", wb_bus.wb_sel_o, mon_b.sel);
                  if (mon_b.we) check("beat_wdat", wb_bus.wb_dat_o, mon_b.dat);
               end
            end
            if (rdata_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_rdata: 0x%0h, expected none", rdata);
               end else begin
                  mon_r = exp_q.pop_front();
                  check("rdata", rdata, mon_r[DW-1:0]);
                  check("rdata_last", rdata_last, mon_r[DW]);
               end
            end
            if (done) begin
               if (exp_done_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_done: done_err %0b, expected no done", done_err);
               end else begin
                  mon_d = exp_done_q.pop_front();
                  check("done_err", done_err, mon_d);
               end
            end
            if (!wb_bus.wb_cyc_o) begin
               check("idle_bus", {wb_bus.wb_stb_o, wb_bus.wb_cti_o, wb_bus.wb_bte_o, rdata_valid}, 0);
            end
         end
      end
   end

   // driver: reference model fills the queues, then the command and write words are driven
   task automatic run_cmd(input logic [AW-1:0] addr, input logic we, input logic [3:0] len,
                          input logic [SW-1:0] sel, input logic wrap, input int ebeat);
      logic [DW-1:0] words[16];
      beat_t         b;
      logic [AW-1:0] w0;
      logic [AW-1:0] a;
      logic          wrap_eff;
      int            n;
      int            nb;
      int            idx;
      int            exp_consumed;
      int            budget;
      int            done_cyc;
      logic          seen_done;

      n         = int'(len) + 1;
      salt      = $urandom;
      wrap_eff  = 1'b0;
      idx       = 0;
      budget    = 0;
      done_cyc  = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
`ifdef OPTIMSOC_WB_BURST_WRAP_EN
      wrap_eff = wrap && (len == 4'd3 || len == 4'd7 || len == 4'd15);
`else
      wrap_eff = 1'b0 & wrap;
`endif
      nb = (ebeat >= 0) ? ebeat + 1 : n;
      for (int i = 0; i < nb; i++) begin
         if (wrap_eff) begin
            w0 = addr / SW;
            a  = ((w0 / n) * n + (w0 % n + i) % n) * SW;
         end else begin
            a = addr + i * SW;
         end
         b.adr = a;
         b.cti = (len == 0) ? 3'b000 : ((i == int'(len)) ? 3'b111 : 3'b010);
         b.bte = !wrap_eff ? 2'b00 : (len == 4'd3) ? 2'b01 : (len == 4'd7) ? 2'b10 : 2'b11;
         b.we  = we;
         b.sel = sel;
         b.dat = words[i];
         exp_beat_q.push_back(b);
         if (!we && i != ebeat) exp_q.push_back({i == int'(len), mem_word(a)});
      end
      exp_done_q.push_back(ebeat >= 0);
      exp_consumed = !we ? 0 : (ebeat == int'(len)) ? n - 1 : n;

      err_beat = ebeat;
      slv_beat = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_we    = we;
      cmd_len   = len;
      cmd_sel   = sel;
      cmd_wrap  = wrap;
      @(negedge clk);
      check("cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      while (!seen_done && budget < 400) begin
         if (we && idx < n && (int'($urandom_range(99)) >= gap_pct)) begin
            wdata_valid = 1'b1;
            wdata       = words[idx];
         end else begin
            wdata_valid = 1'b0;
         end
         @(negedge clk);
         if (wdata_valid && wdata_ready) idx++;
         if (done) begin
            seen_done = 1'b1;
            done_cyc  = cyc_cnt;
         end
         @(posedge clk);
         #1;
         budget++;
      end
      wdata_valid = 1'b0;
      if (!seen_done) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: no done after %0d cycles, expected done", budget);
         exp_beat_q.delete();
         exp_q.delete();
         exp_done_q.delete();
      end else begin
         check("wdata_consumed", idx, exp_consumed);
         if (!(we && ebeat >= 0 && ebeat < int'(len)))
            check("done_latency", done_cyc - last_resp_cyc, 1);
         check("beats_left", exp_beat_q.size(), 0);
         check("rdata_left", exp_q.size(), 0);
      end
   endtask

   logic [AW-1:0] r_addr;
   logic [3:0]    r_len;
   int            r_err;
   logic          no_done;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_outputs", {wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_cti_o,
                            wb_bus.wb_bte_o, wb_bus.wb_adr_o, wb_bus.wb_sel_o, wdata_ready,
                            rdata_valid, rdata_last, done, done_err}, 0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      stall_pct = 0;
      gap_pct   = 0;
      run_cmd(32'h100, 1'b0, 4'd3, 4'hF, 1'b0, -1);
      run_cmd(32'h40, 1'b1, 4'd0, 4'h3, 1'b0, -1);
      gap_pct   = 40;
      stall_pct = 20;
      run_cmd(32'h0, 1'b1, 4'd7, 4'hF, 1'b0, -1);
      stall_pct = 0;
      gap_pct   = 0;
      run_cmd(32'h200, 1'b0, 4'd7, 4'hF, 1'b0, 2);
      run_cmd(32'h300, 1'b1, 4'd3, 4'hF, 1'b0, 1);
      run_cmd(32'h18, 1'b0, 4'd7, 4'hF, 1'b1, -1);
      run_cmd(32'h74, 1'b1, 4'd15, 4'hC, 1'b1, -1);
      run_cmd(32'h38, 1'b0, 4'd3, 4'h1, 1'b1, -1);
      run_cmd(32'h38, 1'b0, 4'd5, 4'hF, 1'b1, -1);
      run_cmd(32'h500, 1'b1, 4'd3, 4'hF, 1'b0, 3);
      run_cmd(32'h600, 1'b0, 4'd0, 4'hF, 1'b0, 0);
      run_cmd(32'h700, 1'b1, 4'd15, 4'hF, 1'b0, 0);
      run_cmd(32'hFFFF_FFF8, 1'b0, 4'd3, 4'hF, 1'b0, -1);

      for (int k = 0; k < 150; k++) begin
         stall_pct = $urandom_range(0, 50);
         gap_pct   = $urandom_range(0, 50);
         r_addr    = $urandom & ~AW'(SW - 1);
         r_len     = 4'($urandom_range(0, 15));
         r_err     = ($urandom_range(3) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
         run_cmd(r_addr, 1'($urandom_range(1)), r_len, SW'($urandom_range(1, 15)),
                 1'($urandom_range(1)), r_err);
      end

      // reset in the middle of a long read burst
      mon_en    = 1'b0;
      stall_pct = 30;
      err_beat  = -1;
      slv_beat  = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = 32'h800;
      cmd_we    = 1'b0;
      cmd_len   = 4'd15;
      cmd_sel   = 4'hF;
      cmd_wrap  = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrst_busy", wb_bus.wb_cyc_o, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_outputs", {wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_cti_o,
                               wb_bus.wb_adr_o, wb_bus.wb_sel_o, rdata_valid, done}, 0);
      no_done = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done) no_done = 1'b1;
      end
      check("midrst_no_done", no_done, 0);
      exp_beat_q.delete();
      exp_q.delete();
      exp_done_q.delete();
      mon_en    = 1'b1;
      stall_pct = 10;
      run_cmd(32'h900, 1'b0, 4'd3, 4'hF, 1'b0, -1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
